// File: rtl/mem_port_mux.sv
// Shared memory port multiplexer behind the 4-way sub_arbiter.
// Routes the granted master's request onto one registered memory port,
// returns fixed-latency read data through a tag pipeline, and keeps
// per-master saturating access counters for profiling.

// Per-master 16-bit saturating access counter.
module mem_port_acc_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  // Count accepted accesses, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (inc && (cnt != 16'hFFFF))  cnt <= cnt + 16'd1;
  end

endmodule

module mem_port_mux #(
  parameter int NM     = 4,
  parameter int AW     = 13,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM-1:0]    gnt,
  input  logic [NM-1:0]    m_valid,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM-1:0]    m_ready,
  output logic [NM-1:0]    m_rvalid,
  output logic [DW-1:0]    m_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             grant_err,
  output logic [NM*16-1:0] acc_cnt
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  // A grant is usable only if exactly one bit is set; a multi-hot grant
  // blocks every master so two requests can never collide on the port.
  logic multi, onehot;
  assign multi   = |(gnt & (gnt - NM'(1)));
  assign onehot  = (|gnt) & ~multi;
  assign m_ready = gnt & m_valid & {NM{onehot}};

  // Encode the single accepted master into an index.
  logic [IW-1:0] sel;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NM; i++)
      if (m_ready[i]) sel = IW'(i);
  end

  // Issue register: one access per cycle; addr/wdata/id hold when idle.
  logic [IW-1:0] mem_id;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_id    <= '0;
    end else begin
      mem_en <= |m_ready;
      mem_we <= (|m_ready) & m_we[sel];
      if (|m_ready) begin
        mem_addr  <= m_addr[sel*AW +: AW];
        mem_wdata <= m_wdata[sel*DW +: DW];
        mem_id    <= sel;
      end
    end
  end

  // Tag pipeline: the last stage lines up with the cycle mem_rdata is valid.
  // It never stalls, so a grant change cannot disturb reads in flight.
  logic [RD_LAT-1:0]         vld_pipe;
  logic [RD_LAT-1:0][IW-1:0] id_pipe;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= mem_en & ~mem_we;
      id_pipe[0]  <= mem_id;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  // Response register: steer the valid to the originator, hold data otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid <= '0;
      m_rdata  <= '0;
    end else begin
      m_rvalid <= vld_pipe[RD_LAT-1] ? (NM'(1) << id_pipe[RD_LAT-1]) : '0;
      if (vld_pipe[RD_LAT-1]) m_rdata <= mem_rdata;
    end
  end

  // Sticky flag for an upstream arbiter that ever issued a multi-hot grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     grant_err <= 1'b0;
    else if (multi) grant_err <= 1'b1;
  end

  for (genvar i = 0; i < NM; i++) begin : g_cnt
    mem_port_acc_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (m_ready[i]),
      .cnt   (acc_cnt[i*16 +: 16])
    );
  end

endmodule

// File: doc/mem_port_mux.md
# mem_port_mux

Downstream stage of the 4-way `sub_arbiter`. Takes the one-hot grant vector and the request buses of up to four masters and drives a single shared memory port (user-project BRAM/SDRAM front end). Routes fixed-latency read data back to the originating master via an in-flight tag pipeline. Keeps per-master saturating access counters for WLOS profiling.

## Interface
- `NM`, 4, number of masters; equals the arbiter `req`/`gnt` width
- `AW`, 13, memory word-address width
- `DW`, 32, data width
- `RD_LAT`, 2, memory read latency in cycles (≥1) from `mem_en` cycle to `mem_rdata` valid

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `gnt`  in  NM  grant vector from `sub_arbiter`; expected one-hot or zero
- `m_valid`  in  NM  per-master request valid
- `m_we`  in  NM  per-master write enable (1 write, 0 read)
- `m_addr`  in  NM*AW  packed addresses, master i at `[i*AW +: AW]`
- `m_wdata`  in  NM*DW  packed write data, master i at `[i*DW +: DW]`
- `m_ready`  out  NM  combinational accept strobe per master
- `m_rvalid`  out  NM  registered read-response valid per master
- `m_rdata`  out  DW  registered read data, shared by all masters
- `mem_en`  out  1  registered memory access enable
- `mem_we`  out  1  registered memory write enable
- `mem_addr`  out  AW  registered memory address
- `mem_wdata`  out  DW  registered memory write data
- `mem_rdata`  in  DW  memory read data
- `grant_err`  out  1  sticky: multi-hot `gnt` seen
- `acc_cnt`  out  NM*16  packed per-master accepted-access counters

## Operation
- Accept: `m_ready[i] = gnt[i] & m_valid[i] & onehot(gnt)`. At most one bit of `m_ready` high per cycle.
- Issue register (every cycle):
  - `mem_en <= |m_ready`
  - `mem_we <= m_we[sel]`
  - `mem_addr <= m_addr[sel]`
  - `mem_wdata <= m_wdata[sel]`
  - `sel` = index of the set `m_ready` bit.
  - With no accept: `mem_en`/`mem_we` go 0; addr/wdata hold their last value.
- Tag pipeline: `RD_LAT` stages of {valid, id[log2 NM]}.
  - Stage 0 loads {`mem_en & ~mem_we`, id of issued access}; it advances every cycle with no stall.
  - Its output stage is aligned with the cycle `mem_rdata` is valid.
- Response register: `m_rvalid <= tag_valid ? (1 << tag_id) : 0`. `m_rdata` loads `mem_rdata` when `tag_valid`, else holds.
- Writes produce no response.
- `gnt` zero: no accept, no error.
- `gnt` multi-hot (≥2 bits): no accept that cycle; `grant_err` set next edge. It stays set until reset.
- `acc_cnt[i]` increments by 1 on each edge with `m_ready[i]=1`, for reads and writes alike. Saturates at 16'hFFFF with no wrap.

## Timing
- Reset (`rst_n`=0, immediate):
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` = 0
  - `m_rvalid` = 0, `m_rdata` = 0
  - all tag valids = 0
  - `acc_cnt` = 0, `grant_err` = 0
  - `m_ready` is combinational and follows its inputs.
- Reset mid-operation: in-flight reads are dropped; no `m_rvalid` appears after release.
- Accept in cycle T: `mem_*` valid in T+1. For a read, `mem_rdata` is valid in T+1+RD_LAT, and `m_rvalid[i]`/`m_rdata` are valid in T+2+RD_LAT. Total read latency is RD_LAT+2 cycles.
- Throughput: one access per cycle; back-to-back reads from different masters return in issue order, one per cycle.
- A master holds `m_valid` and its bus fields until it samples `m_ready`=1. Dropping `m_valid` without `m_ready` is legal (request withdrawn).
- A grant change between cycles has no effect on in-flight reads.

## Test plan
- Single read: `gnt`=0001, `m_valid`=0001, `m_we`=0, `m_addr[0]`=0x010 at T. Required:
  - `m_ready`=0001 at T
  - `mem_en`=1, `mem_addr`=0x010 at T+1
  - memory returns 0xDEADBEEF at T+3
  - `m_rvalid`=0001, `m_rdata`=0xDEADBEEF at T+4
- Back-to-back mixed masters: reads granted to m0, m1, m3 on three consecutive cycles. Required: `m_rvalid` = 0001, 0010, 1000 on consecutive cycles, each with the matching data. `acc_cnt` for m0, m1, m3 = 1 each.
- Write: `gnt`=0100, `m_we[2]`=1, addr 0x1FFF, data 0x12345678. Required: `mem_en`=`mem_we`=1 with those values next cycle; no `m_rvalid` ever.
- Multi-hot `gnt`=0011 with both valid. Required: `m_ready`=0000, `mem_en`=0 next cycle, `grant_err`=1 and staying 1 afterwards.
- Reset mid-read: assert `rst_n`=0 one cycle after a read accept. Required: all outputs zero immediately, and no `m_rvalid` after release.
- Saturation: 65540 consecutive accepts on m1. Required: `acc_cnt[1]`=0xFFFF and remaining there.
